// File: rtl/synch_fifo_flex.sv
// synch_fifo_flex: single-clock FIFO of any depth >= 2 with registered-read or
// first-word-fall-through output, almost-full/empty levels, sticky error flags
// and synchronous flush.
module synch_fifo_flex #(
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_PTR   = $clog2(FIFO_DEPTH),
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_flush,
  input  logic                  fifo_clr_err,
  input  logic                  fifo_wren,
  input  logic [FIFO_WIDTH-1:0] fifo_wrdata,
  input  logic                  fifo_rden,
  output logic [FIFO_WIDTH-1:0] fifo_rddata,
  output logic                  fifo_rdvalid,
  input  logic [FIFO_PTR:0]     fifo_af_level,
  input  logic [FIFO_PTR:0]     fifo_ae_level,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  fifo_almost_full,
  output logic                  fifo_almost_empty,
  output logic [FIFO_PTR:0]     fifo_room_avail,
  output logic [FIFO_PTR:0]     fifo_data_avail,
  output logic                  fifo_overflow,
  output logic                  fifo_underflow
);

  localparam int CW = FIFO_PTR + 1;
  localparam logic [CW-1:0]       DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [FIFO_PTR-1:0] LAST_C  = FIFO_PTR'(FIFO_DEPTH - 1);

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [FIFO_PTR-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_ovf, r_udf;

  logic                  w_full, w_empty;
  logic                  w_rd_ok, w_wr_ok;
  logic                  w_ovf_evt, w_udf_evt;
  logic [FIFO_PTR-1:0]   w_wr_ptr_nxt, w_rd_ptr_nxt;

  // Status is a pure function of the registered count.
  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);

  // Flush swallows any same-cycle request, so it gates both accepts and errors.
  // A write on full is allowed when a read frees the slot in the same cycle.
  assign w_rd_ok   = !fifo_flush && fifo_rden && !w_empty;
  assign w_wr_ok   = !fifo_flush && fifo_wren && (!w_full || w_rd_ok);
  assign w_ovf_evt = !fifo_flush && fifo_wren && !w_wr_ok;
  assign w_udf_evt = !fifo_flush && fifo_rden && !w_rd_ok;

  // Explicit wrap so non-power-of-two depths work.
  assign w_wr_ptr_nxt = (r_wr_ptr == LAST_C) ? '0 : r_wr_ptr + FIFO_PTR'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == LAST_C) ? '0 : r_rd_ptr + FIFO_PTR'(1);

  // Pointer and occupancy state; flush returns to the empty state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (fifo_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_rd_ok) r_rd_ptr <= w_rd_ptr_nxt;
      if (w_wr_ok && !w_rd_ok)      r_count <= r_count + CW'(1);
      else if (!w_wr_ok && w_rd_ok) r_count <= r_count - CW'(1);
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= fifo_wrdata;
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_ovf_evt)         r_ovf <= 1'b1;
      else if (fifo_clr_err) r_ovf <= 1'b0;
      if (w_udf_evt)         r_udf <= 1'b1;
      else if (fifo_clr_err) r_udf <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always presented; masked to zero while empty so the
      // output is defined out of reset.
      assign fifo_rddata  = w_empty ? '0 : r_mem[r_rd_ptr];
      assign fifo_rdvalid = !w_empty;
    end else begin : g_regrd
      logic [FIFO_WIDTH-1:0] r_rddata;
      logic                  r_rdvalid;
      // Registered read: data captured on an accepted read, valid for one cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rddata  <= '0;
          r_rdvalid <= 1'b0;
        end else begin
          r_rdvalid <= w_rd_ok;
          if (w_rd_ok) r_rddata <= r_mem[r_rd_ptr];
        end
      end
      assign fifo_rddata  = r_rddata;
      assign fifo_rdvalid = r_rdvalid;
    end
  endgenerate

  assign fifo_full         = w_full;
  assign fifo_empty        = w_empty;
  assign fifo_almost_full  = (fifo_af_level != '0) && (r_count >= fifo_af_level);
  assign fifo_almost_empty = (r_count <= fifo_ae_level);
  assign fifo_room_avail   = DEPTH_C - r_count;
  assign fifo_data_avail   = r_count;
  assign fifo_overflow     = r_ovf;
  assign fifo_underflow    = r_udf;

endmodule

// File: tb/tb_synch_fifo_flex.sv
// Directed bench for synch_fifo_flex: depth-16 registered-read, depth-12
// registered-read and depth-16 FWFT instances share clock and reset.
module tb_synch_fifo_flex;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;

  // instance A: depth 16, registered read
  logic        a_flush = 0, a_clr = 0, a_wren = 0, a_rden = 0;
  logic [31:0] a_wdata = 0, a_rdata;
  logic        a_rdvalid, a_full, a_empty, a_afull, a_aempty, a_ovf, a_udf;
  logic [4:0]  a_af = 0, a_ae = 0, a_room, a_avail;
  // instance B: depth 12, registered read
  logic        b_flush = 0, b_clr = 0, b_wren = 0, b_rden = 0;
  logic [31:0] b_wdata = 0, b_rdata;
  logic        b_rdvalid, b_full, b_empty, b_afull, b_aempty, b_ovf, b_udf;
  logic [4:0]  b_af = 0, b_ae = 0, b_room, b_avail;
  // instance C: depth 16, FWFT
  logic        c_flush = 0, c_clr = 0, c_wren = 0, c_rden = 0;
  logic [31:0] c_wdata = 0, c_rdata;
  logic        c_rdvalid, c_full, c_empty, c_afull, c_aempty, c_ovf, c_udf;
  logic [4:0]  c_af = 0, c_ae = 0, c_room, c_avail;

  synch_fifo_flex #(.FIFO_WIDTH(32), .FIFO_DEPTH(16), .FWFT(0)) u_a (
    .clk(clk), .rst(rst), .fifo_flush(a_flush), .fifo_clr_err(a_clr),
    .fifo_wren(a_wren), .fifo_wrdata(a_wdata), .fifo_rden(a_rden),
    .fifo_rddata(a_rdata), .fifo_rdvalid(a_rdvalid),
    .fifo_af_level(a_af), .fifo_ae_level(a_ae),
    .fifo_full(a_full), .fifo_empty(a_empty),
    .fifo_almost_full(a_afull), .fifo_almost_empty(a_aempty),
    .fifo_room_avail(a_room), .fifo_data_avail(a_avail),
    .fifo_overflow(a_ovf), .fifo_underflow(a_udf));

  synch_fifo_flex #(.FIFO_WIDTH(32), .FIFO_DEPTH(12), .FWFT(0)) u_b (
    .clk(clk), .rst(rst), .fifo_flush(b_flush), .fifo_clr_err(b_clr),
    .fifo_wren(b_wren), .fifo_wrdata(b_wdata), .fifo_rden(b_rden),
    .fifo_rddata(b_rdata), .fifo_rdvalid(b_rdvalid),
    .fifo_af_level(b_af), .fifo_ae_level(b_ae),
    .fifo_full(b_full), .fifo_empty(b_empty),
    .fifo_almost_full(b_afull), .fifo_almost_empty(b_aempty),
    .fifo_room_avail(b_room), .fifo_data_avail(b_avail),
    .fifo_overflow(b_ovf), .fifo_underflow(b_udf));

  synch_fifo_flex #(.FIFO_WIDTH(32), .FIFO_DEPTH(16), .FWFT(1)) u_c (
    .clk(clk), .rst(rst), .fifo_flush(c_flush), .fifo_clr_err(c_clr),
    .fifo_wren(c_wren), .fifo_wrdata(c_wdata), .fifo_rden(c_rden),
    .fifo_rddata(c_rdata), .fifo_rdvalid(c_rdvalid),
    .fifo_af_level(c_af), .fifo_ae_level(c_ae),
    .fifo_full(c_full), .fifo_empty(c_empty),
    .fifo_almost_full(c_afull), .fifo_almost_empty(c_aempty),
    .fifo_room_avail(c_room), .fifo_data_avail(c_avail),
    .fifo_overflow(c_ovf), .fifo_underflow(c_udf));

  // advance one clock and settle past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    total++; if (a_empty !== 1'b1) $display("FAIL rst_empty got=%0b exp=1", a_empty); else pass_cnt++;
    total++; if (a_full !== 1'b0) $display("FAIL rst_full got=%0b exp=0", a_full); else pass_cnt++;
    total++; if (a_room !== 5'd16) $display("FAIL rst_room got=%0d exp=16", a_room); else pass_cnt++;
    total++; if (a_avail !== 5'd0) $display("FAIL rst_avail got=%0d exp=0", a_avail); else pass_cnt++;
    total++; if (a_ovf !== 1'b0) $display("FAIL rst_ovf got=%0b exp=0", a_ovf); else pass_cnt++;
    total++; if (a_aempty !== 1'b1 || a_afull !== 1'b0) $display("FAIL rst_almost got=%0b%0b exp=01", a_afull, a_aempty); else pass_cnt++;
    total++; if (a_rdvalid !== 1'b0 || a_rdata !== 32'h0) $display("FAIL rst_rd got=%0b/%0h exp=0/0", a_rdvalid, a_rdata); else pass_cnt++;
    total++; if (b_room !== 5'd12) $display("FAIL rst_room12 got=%0d exp=12", b_room); else pass_cnt++;
  endtask

  task automatic test_fill();
    logic [31:0] words [17];
    int pulses = 0;
    for (int i = 0; i < 17; i++) words[i] = $urandom;
    for (int i = 0; i < 17; i++) begin
      a_wren = 1'b1; a_wdata = words[i];
      tick();
      if (i == 14) begin
        total++; if (a_full !== 1'b0) $display("FAIL fill_full15 got=%0b exp=0", a_full); else pass_cnt++;
      end
      if (i == 15) begin
        total++; if (a_full !== 1'b1) $display("FAIL fill_full16 got=%0b exp=1", a_full); else pass_cnt++;
        total++; if (a_ovf !== 1'b0) $display("FAIL fill_ovf16 got=%0b exp=0", a_ovf); else pass_cnt++;
      end
    end
    a_wren = 1'b0;
    total++; if (a_ovf !== 1'b1) $display("FAIL fill_ovf17 got=%0b exp=1", a_ovf); else pass_cnt++;
    total++; if (a_avail !== 5'd16) $display("FAIL fill_avail got=%0d exp=16", a_avail); else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      a_rden = 1'b1;
      tick();
      pulses += int'(a_rdvalid);
      total++; if (a_rdata !== words[i]) $display("FAIL fill_rd%0d got=%h exp=%h", i, a_rdata, words[i]); else pass_cnt++;
    end
    a_rden = 1'b0;
    tick();
    pulses += int'(a_rdvalid);
    total++; if (pulses != 16) $display("FAIL fill_pulses got=%0d exp=16", pulses); else pass_cnt++;
    total++; if (a_empty !== 1'b1) $display("FAIL fill_empty got=%0b exp=1", a_empty); else pass_cnt++;
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    total++; if (a_ovf !== 1'b0) $display("FAIL clr_ovf got=%0b exp=0", a_ovf); else pass_cnt++;
  endtask

  task automatic test_full_rdwr();
    logic [31:0] q [$];
    logic [31:0] exp_d;
    for (int i = 0; i < 16; i++) begin
      a_wren = 1'b1; a_wdata = 32'hC000_0000 + i;
      q.push_back(a_wdata);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      a_wren = 1'b1; a_rden = 1'b1; a_wdata = 32'hD000_0000 + i;
      exp_d = q.pop_front();
      q.push_back(a_wdata);
      tick();
      total++; if (a_rdvalid !== 1'b1 || a_rdata !== exp_d) $display("FAIL rw_rd%0d got=%0b/%h exp=1/%h", i, a_rdvalid, a_rdata, exp_d); else pass_cnt++;
      total++; if (a_avail !== 5'd16) $display("FAIL rw_cnt%0d got=%0d exp=16", i, a_avail); else pass_cnt++;
      total++; if (a_ovf !== 1'b0) $display("FAIL rw_ovf%0d got=%0b exp=0", i, a_ovf); else pass_cnt++;
    end
    a_wren = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a_rden = 1'b1;
      exp_d = q.pop_front();
      tick();
      total++; if (a_rdata !== exp_d) $display("FAIL rw_drain%0d got=%h exp=%h", i, a_rdata, exp_d); else pass_cnt++;
    end
    a_rden = 1'b0;
    tick();
    total++; if (a_empty !== 1'b1) $display("FAIL rw_empty got=%0b exp=1", a_empty); else pass_cnt++;
  endtask

  task automatic test_wrap12();
    logic [31:0] q [$];
    logic [31:0] exp_d;
    int sent = 0, got = 0, cyc = 0;
    bit wr, rd, rok, wok;
    exp_d = 0;
    while (got < 40 && cyc < 3000) begin
      wr = (sent < 40) && ($urandom_range(0, 2) != 0);
      rd = ($urandom_range(0, 1) != 0);
      b_wren = wr; b_rden = rd; b_wdata = 32'h1000 + sent;
      rok = rd && (q.size() > 0);
      wok = wr && (q.size() < 12 || rok);
      if (rok) exp_d = q.pop_front();
      if (wok) begin q.push_back(32'h1000 + sent); sent++; end
      tick();
      cyc++;
      if (rok) begin
        got++;
        total++; if (b_rdvalid !== 1'b1 || b_rdata !== exp_d) $display("FAIL wrap_rd got=%0b/%h exp=1/%h", b_rdvalid, b_rdata, exp_d); else pass_cnt++;
      end else begin
        total++; if (b_rdvalid !== 1'b0) $display("FAIL wrap_rdv got=%0b exp=0", b_rdvalid); else pass_cnt++;
      end
      total++; if (int'(b_avail) != q.size()) $display("FAIL wrap_cnt got=%0d exp=%0d", b_avail, q.size()); else pass_cnt++;
      total++; if (int'(b_avail) + int'(b_room) != 12) $display("FAIL wrap_sum got=%0d exp=12", int'(b_avail) + int'(b_room)); else pass_cnt++;
    end
    b_wren = 1'b0; b_rden = 1'b0;
    total++; if (got != 40) $display("FAIL wrap_timeout got=%0d exp=40", got); else pass_cnt++;
  endtask

  task automatic test_fwft();
    c_wren = 1'b1; c_wdata = 32'hA5A5A5A5;
    tick();
    c_wren = 1'b0;
    total++; if (c_empty !== 1'b0 || c_rdvalid !== 1'b1) $display("FAIL fwft_vis got=%0b/%0b exp=0/1", c_empty, c_rdvalid); else pass_cnt++;
    total++; if (c_rdata !== 32'hA5A5A5A5) $display("FAIL fwft_data got=%h exp=a5a5a5a5", c_rdata); else pass_cnt++;
    c_rden = 1'b1;
    tick();
    c_rden = 1'b0;
    total++; if (c_empty !== 1'b1 || c_rdvalid !== 1'b0) $display("FAIL fwft_pop got=%0b/%0b exp=1/0", c_empty, c_rdvalid); else pass_cnt++;
    c_wren = 1'b1; c_wdata = 32'hB1;
    tick();
    c_wdata = 32'hB2;
    tick();
    c_wren = 1'b0;
    total++; if (c_rdata !== 32'hB1) $display("FAIL fwft_head got=%h exp=b1", c_rdata); else pass_cnt++;
    c_rden = 1'b1;
    tick();
    total++; if (c_rdata !== 32'hB2 || c_rdvalid !== 1'b1) $display("FAIL fwft_next got=%0b/%h exp=1/b2", c_rdvalid, c_rdata); else pass_cnt++;
    tick();
    total++; if (c_empty !== 1'b1 || c_udf !== 1'b0) $display("FAIL fwft_drain got=%0b/%0b exp=1/0", c_empty, c_udf); else pass_cnt++;
    tick();
    total++; if (c_udf !== 1'b1) $display("FAIL fwft_udf got=%0b exp=1", c_udf); else pass_cnt++;
    c_clr = 1'b1;
    tick();
    total++; if (c_udf !== 1'b1) $display("FAIL fwft_errwins got=%0b exp=1", c_udf); else pass_cnt++;
    c_rden = 1'b0;
    tick();
    c_clr = 1'b0;
    total++; if (c_udf !== 1'b0) $display("FAIL fwft_clr got=%0b exp=0", c_udf); else pass_cnt++;
  endtask

  task automatic test_levels_flush_reset();
    a_af = 5'd12; a_ae = 5'd2;
    #1;
    total++; if (a_afull !== 1'b0 || a_aempty !== 1'b1) $display("FAIL lvl_init got=%0b%0b exp=01", a_afull, a_aempty); else pass_cnt++;
    for (int n = 1; n <= 12; n++) begin
      a_wren = 1'b1; a_wdata = 32'hE000 + n;
      tick();
      total++; if (a_afull !== (n >= 12)) $display("FAIL lvl_af n=%0d got=%0b exp=%0b", n, a_afull, (n >= 12)); else pass_cnt++;
      total++; if (a_aempty !== (n <= 2)) $display("FAIL lvl_ae n=%0d got=%0b exp=%0b", n, a_aempty, (n <= 2)); else pass_cnt++;
    end
    a_flush = 1'b1; a_wren = 1'b1;
    tick();
    a_flush = 1'b0; a_wren = 1'b0;
    total++; if (a_avail !== 5'd0 || a_empty !== 1'b1) $display("FAIL flush_cnt got=%0d/%0b exp=0/1", a_avail, a_empty); else pass_cnt++;
    total++; if (a_aempty !== 1'b1 || a_afull !== 1'b0) $display("FAIL flush_lvl got=%0b%0b exp=01", a_afull, a_aempty); else pass_cnt++;
    total++; if (a_ovf !== 1'b0 || a_rdvalid !== 1'b0) $display("FAIL flush_ovf got=%0b/%0b exp=0/0", a_ovf, a_rdvalid); else pass_cnt++;
    a_wren = 1'b1; a_wdata = 32'h77;
    tick(); tick();
    total++; if (a_avail !== 5'd2) $display("FAIL mid_cnt got=%0d exp=2", a_avail); else pass_cnt++;
    a_rden = 1'b1;
    tick();
    #2 rst = 1'b1;
    #1;
    total++; if (a_empty !== 1'b1 || a_full !== 1'b0 || a_avail !== 5'd0 || a_room !== 5'd16) $display("FAIL arst_cnt got=%0b%0b/%0d/%0d exp=10/0/16", a_empty, a_full, a_avail, a_room); else pass_cnt++;
    total++; if (a_rdvalid !== 1'b0 || a_rdata !== 32'h0) $display("FAIL arst_rd got=%0b/%h exp=0/0", a_rdvalid, a_rdata); else pass_cnt++;
    total++; if (a_afull !== 1'b0 || a_aempty !== 1'b1 || a_ovf !== 1'b0 || a_udf !== 1'b0) $display("FAIL arst_flags got=%0b%0b%0b%0b exp=0100", a_afull, a_aempty, a_ovf, a_udf); else pass_cnt++;
    a_wren = 1'b0; a_rden = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_rdwr();
    test_wrap12();
    test_fwft();
    test_levels_flush_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
